// File: rtl/pkt_read_arbiter.sv
// Round-robin read arbiter: four transmit ports share one packet-buffer RAM read port.
// Optional per-port grant statistics are enabled by defining PKT_READ_STAT_EN.
module pkt_read_arbiter #(
  parameter int RAM_LATENCY = 2,
  parameter int PORT_NUM    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [16*PORT_NUM-1:0]   iv_pkt_raddr,
  input  logic [PORT_NUM-1:0]      i_pkt_rd,
  output logic [PORT_NUM-1:0]      o_pkt_raddr_ack,
  output logic [133:0]             ov_pkt_data,
  output logic [PORT_NUM-1:0]      o_pkt_data_wr,
  output logic [15:0]              ov_ram_raddr,
  output logic                     o_ram_rd,
  input  logic [133:0]             iv_ram_rdata,
  output logic [16*PORT_NUM-1:0]   ov_rd_cnt
);

  logic [1:0]          last_grant;
  logic [1:0]          gnt_id;
  logic [1:0]          idx;
  logic                gnt_vld;
  logic [PORT_NUM-1:0] elig;
  logic [PORT_NUM-1:0] gnt_oh;
  logic [PORT_NUM-1:0] pipe [RAM_LATENCY];

  // The registered ack doubles as the one-cycle mask against re-granting a held request.
  always_comb begin
    elig    = i_pkt_rd & ~o_pkt_raddr_ack;
    gnt_vld = 1'b0;
    gnt_id  = last_grant;
    idx     = last_grant;
    for (int i = 0; i < PORT_NUM; i++) begin
      idx = last_grant + 2'(i + 1);
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
    gnt_oh = PORT_NUM'(1) << gnt_id;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last_grant      <= 2'd3;
      o_ram_rd        <= 1'b0;
      o_pkt_raddr_ack <= '0;
      ov_ram_raddr    <= '0;
      o_pkt_data_wr   <= '0;
      ov_pkt_data     <= '0;
      for (int k = 0; k < RAM_LATENCY; k++) pipe[k] <= '0;
    end else begin
      o_ram_rd        <= gnt_vld;
      o_pkt_raddr_ack <= gnt_vld ? gnt_oh : '0;
      if (gnt_vld) begin
        ov_ram_raddr <= iv_pkt_raddr[{gnt_id, 4'b0000} +: 16];
        last_grant   <= gnt_id;
      end
      // Owner tracking starts the cycle after o_ram_rd; the last stage lines up with valid RAM data.
      pipe[0] <= o_pkt_raddr_ack;
      for (int k = 1; k < RAM_LATENCY; k++) pipe[k] <= pipe[k-1];
      o_pkt_data_wr <= pipe[RAM_LATENCY-1];
      if (|pipe[RAM_LATENCY-1]) ov_pkt_data <= iv_ram_rdata;
    end
  end

`ifdef PKT_READ_STAT_EN
  logic [15:0] cnt [PORT_NUM];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int p = 0; p < PORT_NUM; p++) cnt[p] <= '0;
    end else if (gnt_vld) begin
      cnt[gnt_id] <= cnt[gnt_id] + 16'd1;
    end
  end

  always_comb begin
    ov_rd_cnt = '0;
    for (int p = 0; p < PORT_NUM; p++) ov_rd_cnt[16*p +: 16] = cnt[p];
  end
`else
  assign ov_rd_cnt = '0;
`endif

endmodule

// File: doc/pkt_read_arbiter.md
PKT_READ_ARBITER -- requirements
Module: pkt_read_arbiter

Interface
REQ-001 Parameter RAM_LATENCY, default 2: cycles from o_ram_rd to valid iv_ram_rdata; legal range 1..4.
REQ-002 Parameter PORT_NUM, fixed 4: number of transmit ports served.
REQ-003 i_clk  input  1  single clock for all logic.
REQ-004 i_rst_n  input  1  synchronous, active-low reset, sampled on i_clk rising edge.
REQ-005 iv_pkt_raddr  input  64  read address per port; port n occupies bits [16n+15:16n].
REQ-006 i_pkt_rd  input  4  read request per port, held with address until acknowledged.
REQ-007 o_pkt_raddr_ack  output  4  one-cycle acknowledge per port; at most one bit set.
REQ-008 ov_pkt_data  output  134  returned packet-buffer word, shared by all ports.
REQ-009 o_pkt_data_wr  output  4  one-hot data-valid strobe selecting the owning port.
REQ-010 ov_ram_raddr  output  16  address to centralized packet buffer RAM.
REQ-011 o_ram_rd  output  1  RAM read strobe.
REQ-012 iv_ram_rdata  input  134  RAM read data, valid exactly RAM_LATENCY cycles after o_ram_rd.
REQ-013 ov_rd_cnt  output  64  per-port grant counters, 16 bits each, port n at [16n+15:16n].

Function
REQ-014 Each cycle the arbiter SHALL select one port among eligible requesters (i_pkt_rd set, not granted in previous cycle) by round-robin, searching from last_grant+1 modulo 4.
REQ-015 Grant decided in cycle N SHALL produce, registered in cycle N+1: o_ram_rd=1, ov_ram_raddr=granted port's address sampled at N, o_pkt_raddr_ack bit of that port =1.
REQ-016 A port granted in cycle N SHALL be masked from arbitration in cycle N+1, preventing double grant of a held request; eligible again from N+2.
REQ-017 With no eligible requester, o_ram_rd and o_pkt_raddr_ack SHALL be 0 next cycle; ov_ram_raddr holds its last value; last_grant unchanged.
REQ-018 last_grant SHALL update only on a grant; reset value 3, so port 0 wins first when all request.
REQ-019 A port-ID/valid shift pipeline of depth RAM_LATENCY SHALL track each issued read; when the tracked entry emerges, ov_pkt_data SHALL register iv_ram_rdata and o_pkt_data_wr SHALL pulse the owning port's bit one cycle later (total RAM_LATENCY+1 cycles after o_ram_rd).
REQ-020 Return order SHALL equal issue order; aggregate throughput one read per cycle; per-port throughput one read per two cycles.
REQ-021 ov_pkt_data SHALL hold its last value when o_pkt_data_wr is 0.
REQ-022 Requests that drop before acknowledge SHALL be ignored without error; address changes while unacknowledged are taken as sampled at grant cycle.

Reset
REQ-023 On i_rst_n=0 at a clock edge: o_pkt_raddr_ack=0, o_pkt_data_wr=0, o_ram_rd=0, ov_ram_raddr=0, ov_pkt_data=0, ov_rd_cnt=0, last_grant=3, mask cleared, return pipeline cleared.
REQ-024 Reads in flight at reset SHALL be discarded; no o_pkt_data_wr for them after reset release.
REQ-025 First grant possible in first cycle with i_rst_n=1; first o_ram_rd appears the following cycle.

Configuration
REQ-026 Macro PKT_READ_STAT_EN: defined -> each 16-bit field of ov_rd_cnt increments by 1 on every grant to that port, wrapping 0xFFFF->0x0000; undefined -> ov_rd_cnt tied to 0 and counter logic absent.

Verification
REQ-027 Single port 2 requests addr 0x0123 from cycle 0 -> o_ram_rd and ack[2] at cycle 1 with ov_ram_raddr=0x0123; o_pkt_data_wr=4'b0100 at cycle 1+RAM_LATENCY+1 carrying RAM word of 0x0123; no second grant.
REQ-028 All four ports hold requests continuously from reset release -> grant order 0,1,2,3,0,1... one o_ram_rd per cycle, no port granted two consecutive cycles.
REQ-029 Ports 1 and 3 request continuously -> grants alternate 1,3,1,3; each port receives data every two cycles in issue order.
REQ-030 Reset asserted one cycle after o_ram_rd for port 0 (RAM_LATENCY=2) -> all outputs 0 next edge; no o_pkt_data_wr for port 0 after release.
REQ-031 With PKT_READ_STAT_EN, preload 0xFFFE grants to port 0 then two more -> ov_rd_cnt[15:0]=0x0000; without macro ov_rd_cnt stays 0 throughout.
REQ-032 RAM_LATENCY=1 and =4 rebuild, run REQ-028 stimulus -> data strobe exactly RAM_LATENCY+1 cycles after each o_ram_rd, port IDs match.
